// File: rtl/gs_row_engine.sv
// gs_row_engine: one Gauss-Seidel row update,
//   x_next = (b - sum_j a_j * x_j) * inv_diag
// folded over NMUL multipliers, with valid/ready on both sides.
// Build option: define GS_SAT_EN to clamp out-of-range results to the
// signed X_W range and flag o_sat; otherwise o_x wraps and o_sat is 0.
module gs_row_engine #(
  parameter int N        = 8,
  parameter int NMUL     = 1,
  parameter int A_W      = 8,
  parameter int X_W      = 32,
  parameter int X_FRAC   = 24,
  parameter int INV_W    = 32,
  parameter int INV_FRAC = 30
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_valid,
  output logic                   o_in_ready,
  input  logic [(N-1)*A_W-1:0]   i_a,
  input  logic [(N-1)*X_W-1:0]   i_x,
  input  logic [A_W-1:0]         i_b,
  input  logic [INV_W-1:0]       i_inv_diag,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [X_W-1:0]         o_x,
  output logic                   o_sat
);

  localparam int TERMS  = N - 1;
  localparam int K      = (TERMS + NMUL - 1) / NMUL;  // ACC cycles per row
  localparam int LANES  = K * NMUL;                    // terms padded to whole folds
  localparam int CNT_W  = (K > 1) ? $clog2(K) : 1;
  localparam int PROD_W = A_W + X_W;
  localparam int ACC_W  = A_W + X_W + $clog2(N) + 1;
  localparam int P_W    = ACC_W + INV_W;

  // Rounding constant: half an LSB of the result, i.e. round half toward +inf.
  localparam logic signed [P_W-1:0] HALF = P_W'(1) << (INV_FRAC - 1);
`ifdef GS_SAT_EN
  localparam logic signed [P_W-1:0] X_MAX = (P_W'(1) << (X_W - 1)) - P_W'(1);
  localparam logic signed [P_W-1:0] X_MIN = ~X_MAX;
`endif

  typedef enum logic [1:0] {IDLE, ACC, SCALE, OUT} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [INV_W-1:0]   inv_q, inv_d;
  logic signed [A_W-1:0]     a_q [LANES];
  logic signed [A_W-1:0]     a_d [LANES];
  logic signed [X_W-1:0]     x_q [LANES];
  logic signed [X_W-1:0]     x_d [LANES];
  logic [X_W-1:0]            o_x_q, o_x_d;
  logic                      o_sat_q, o_sat_d;

  logic signed [ACC_W-1:0]   lane_sum;
  logic signed [P_W-1:0]     p;
  logic signed [P_W-1:0]     rounded;
  logic signed [P_W-1:0]     r;

  // Upper bits of r only matter for the clamp decision.
  logic unused_r_hi;
  assign unused_r_hi = ^r[P_W-1:X_W];

  // Next-state, datapath and result computation.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    inv_d    = inv_q;
    a_d      = a_q;
    x_d      = x_q;
    o_x_d    = o_x_q;
    o_sat_d  = o_sat_q;

    // Lanes 0..NMUL-1 always hold the terms for the current fold; the
    // operand registers shift down by NMUL each ACC cycle, padding with 0.
    lane_sum = '0;
    for (int l = 0; l < NMUL; l++) begin
      lane_sum = lane_sum + ACC_W'(PROD_W'(a_q[l]) * PROD_W'(x_q[l]));
    end

    p       = P_W'(acc_q) * P_W'(inv_q);
    rounded = p + HALF;
    r       = rounded >>> INV_FRAC;

    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          for (int i = 0; i < TERMS; i++) begin
            a_d[i] = i_a[(TERMS-1-i)*A_W +: A_W];
            x_d[i] = i_x[(TERMS-1-i)*X_W +: X_W];
          end
          for (int i = TERMS; i < LANES; i++) begin
            a_d[i] = '0;
            x_d[i] = '0;
          end
          acc_d   = ACC_W'($signed(i_b)) <<< X_FRAC;
          inv_d   = $signed(i_inv_diag);
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_q - lane_sum;
        for (int i = 0; i < LANES - NMUL; i++) begin
          a_d[i] = a_q[i+NMUL];
          x_d[i] = x_q[i+NMUL];
        end
        for (int i = LANES - NMUL; i < LANES; i++) begin
          a_d[i] = '0;
          x_d[i] = '0;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(K - 1)) begin
          state_d = SCALE;
        end
      end
      SCALE: begin
`ifdef GS_SAT_EN
        if (r > X_MAX) begin
          o_x_d   = X_MAX[X_W-1:0];
          o_sat_d = 1'b1;
        end else if (r < X_MIN) begin
          o_x_d   = X_MIN[X_W-1:0];
          o_sat_d = 1'b1;
        end else begin
          o_x_d   = r[X_W-1:0];
          o_sat_d = 1'b0;
        end
`else
        o_x_d   = r[X_W-1:0];
        o_sat_d = 1'b0;
`endif
        state_d = OUT;
      end
      OUT: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers, cleared by reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      o_x_q   <= '0;
      o_sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      o_x_q   <= o_x_d;
      o_sat_q <= o_sat_d;
    end
  end

  // Operand registers, loaded on accept before any use.
  always_ff @(posedge i_clk) begin
    // NOTE: operand storage has no reset; it is always written in IDLE
    // before ACC reads it, so a reset would only add fan-out.
    inv_q <= inv_d;
    a_q   <= a_d;
    x_q   <= x_d;
  end

  assign o_in_ready = (state_q == IDLE);
  assign o_valid    = (state_q == OUT);
  assign o_x        = o_x_q;
  assign o_sat      = o_sat_q;

endmodule
